// File: rtl/mcpu_prog_loader_if.sv
// mcpu_prog_loader_if: byte-stream handshake and RAM write bus of the program loader
interface mcpu_prog_loader_if #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
);
    logic                 in_valid;
    logic [7:0]           in_byte;
    logic                 in_ready;
    logic                 mem_we;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    modport master (output in_valid, in_byte, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave (input in_valid, in_byte, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/mcpu_prog_loader.sv
// mcpu_prog_loader: loads a counted, checksummed byte stream of words into MCPU program RAM
module mcpu_prog_loader #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    mcpu_prog_loader_if.slave bus,
    output logic              cpu_reset,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR} state_t;
    state_t               state_q, state_d;
    logic [8:0]           remain_q, remain_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [7:0]           csum_q, csum_d;
    logic [7:0]           hi_q, hi_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 xfer;
    assign xfer = bus.in_valid && bus.in_ready;
    // state and datapath registers, active-low synchronous reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            remain_q <= '0;
            addr_q   <= '0;
            csum_q   <= '0;
            hi_q     <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            addr_q   <= addr_d;
            csum_q   <= csum_d;
            hi_q     <= hi_d;
            wdata_q  <= wdata_d;
        end
    end
    // next state and datapath; remain counts words still to write (count byte 0 means 256)
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        addr_d   = addr_q;
        csum_d   = csum_q;
        hi_d     = hi_q;
        wdata_d  = wdata_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    state_d  = COUNT;
                    remain_d = '0;
                    addr_d   = '0;
                    csum_d   = '0;
                end
            end
            COUNT: begin
                if (xfer) begin
                    state_d  = HI;
                    remain_d = (bus.in_byte == 8'd0) ? 9'd256 : {1'b0, bus.in_byte};
                end
            end
            HI: begin
                if (xfer) begin
                    state_d = LO;
                    hi_d    = bus.in_byte;
                    csum_d  = csum_q ^ bus.in_byte;
                end
            end
            LO: begin
                if (xfer) begin
                    state_d = WRITE;
                    wdata_d = WORD_SIZE'({hi_q, bus.in_byte});
                    csum_d  = csum_q ^ bus.in_byte;
                end
            end
            WRITE: begin
                state_d  = (remain_q == 9'd1) ? CHECK : HI;
                remain_d = remain_q - 9'd1;
                addr_d   = addr_q + ADDR_SIZE'(1);
            end
            CHECK: begin
                if (xfer) state_d = (bus.in_byte == csum_q) ? DONE : ERROR;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs decoded from the current state; write bus comes straight from registers
    always_comb begin
        bus.in_ready  = state_q inside {COUNT, HI, LO, CHECK};
        bus.mem_we    = state_q == WRITE;
        bus.mem_addr  = addr_q;
        bus.mem_wdata = wdata_q;
        cpu_reset     = state_q != DONE;
        done          = state_q == DONE;
        err           = state_q == ERROR;
    end
endmodule

// File: tb/tb_mcpu_prog_loader.sv
// tb_mcpu_prog_loader: directed self-checking bench for the program loader
module tb_mcpu_prog_loader;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic cpu_reset, done, err;
    int vectors = 0;
    int miscompares = 0;
    mcpu_prog_loader_if #(.WORD_SIZE(16), .ADDR_SIZE(8)) bus();
    mcpu_prog_loader #(.WORD_SIZE(16), .ADDR_SIZE(8)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .bus(bus.slave),
        .cpu_reset(cpu_reset),
        .done(done),
        .err(err)
    );
    always #5 clk = ~clk;
    // behavioural RAM and write monitor
    logic [15:0] mem [256];
    logic clr = 1'b0;
    int cyc = 0, last_x = -10, bad_gap = 0, we_ready = 0, wr_cnt = 0;
    logic [7:0] last_we_addr = 8'h00;
    logic [7:0] stream [$];
    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
        end else if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_valid && bus.in_ready) last_x <= cyc;
        if (bus.mem_we) begin
            wr_cnt <= wr_cnt + 1;
            last_we_addr <= bus.mem_addr;
            if (cyc != last_x + 1) bad_gap <= bad_gap + 1;
            if (bus.in_ready) we_ready <= we_ready + 1;
        end
    end
    task automatic clear_mem();
        @(negedge clk) clr = 1'b1;
        @(posedge clk) #1 clr = 1'b0;
    endtask
    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n = 0;
        bit ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            bus.in_byte = b;
            bus.in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ok = bus.in_valid && bus.in_ready;
            n++;
        end
        @(posedge clk) #1 bus.in_valid = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_byte: byte %h not accepted, required acceptance within 200 cycles", b);
        end
    endtask
    task automatic send_stream(input bit rnd);
        foreach (stream[i]) send_byte(stream[i], rnd);
    endtask
    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, cpu_reset} !== 29'h1) begin
            miscompares++;
            $display("FAIL reset_during: got %h required %h", {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, cpu_reset}, 29'h1);
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, cpu_reset} !== 29'h1) begin
            miscompares++;
            $display("FAIL reset_after: got %h required %h", {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, cpu_reset}, 29'h1);
        end
    endtask
    task automatic test_good_load();
        int w0, g0;
        clear_mem();
        w0 = wr_cnt;
        g0 = bad_gap;
        pulse_start();
        vectors++;
        if ({bus.in_ready, cpu_reset} !== 2'b11) begin
            miscompares++;
            $display("FAIL good_count_state: in_ready,cpu_reset got %b required 11", {bus.in_ready, cpu_reset});
        end
        stream = '{8'h02, 8'h14, 8'h0A, 8'h15, 8'h0D, 8'h06};
        send_stream(1'b0);
        @(negedge clk);
        vectors++;
        if ({done, err, cpu_reset} !== 3'b100) begin
            miscompares++;
            $display("FAIL good_flags: done,err,cpu_reset got %b required 100", {done, err, cpu_reset});
        end
        vectors++;
        if ({mem[0], mem[1]} !== 32'h140A_150D) begin
            miscompares++;
            $display("FAIL good_mem: got %h required 140a150d", {mem[0], mem[1]});
        end
        vectors++;
        if (wr_cnt - w0 !== 2 || bad_gap - g0 !== 0) begin
            miscompares++;
            $display("FAIL good_writes: writes %0d late %0d required 2 and 0", wr_cnt - w0, bad_gap - g0);
        end
    endtask
    task automatic test_bad_checksum();
        int w0;
        clear_mem();
        w0 = wr_cnt;
        pulse_start();
        stream = '{8'h02, 8'h14, 8'h0A, 8'h15, 8'h0D, 8'h07};
        send_stream(1'b0);
        @(negedge clk);
        vectors++;
        if ({done, err, cpu_reset} !== 3'b011) begin
            miscompares++;
            $display("FAIL bad_flags: done,err,cpu_reset got %b required 011", {done, err, cpu_reset});
        end
        vectors++;
        if (wr_cnt - w0 !== 2) begin
            miscompares++;
            $display("FAIL bad_writes: got %0d required 2", wr_cnt - w0);
        end
    endtask
    task automatic test_random_valid();
        int w0, g0, r0;
        clear_mem();
        w0 = wr_cnt;
        g0 = bad_gap;
        r0 = we_ready;
        pulse_start();
        stream = '{8'h02, 8'h14, 8'h0A, 8'h15, 8'h0D, 8'h06};
        send_stream(1'b1);
        @(negedge clk);
        vectors++;
        if ({done, err, mem[0], mem[1]} !== {2'b10, 32'h140A_150D}) begin
            miscompares++;
            $display("FAIL random_result: got %h required %h", {done, err, mem[0], mem[1]}, {2'b10, 32'h140A_150D});
        end
        vectors++;
        if (wr_cnt - w0 !== 2 || bad_gap - g0 !== 0 || we_ready - r0 !== 0) begin
            miscompares++;
            $display("FAIL random_writes: writes %0d late %0d ready_in_write %0d required 2,0,0", wr_cnt - w0, bad_gap - g0, we_ready - r0);
        end
    endtask
    task automatic test_mid_reset();
        clear_mem();
        pulse_start();
        stream = '{8'h02, 8'h14, 8'h0A, 8'h15};
        send_stream(1'b0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk) #1;
        vectors++;
        if ({bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, cpu_reset} !== 29'h1) begin
            miscompares++;
            $display("FAIL midreset_outputs: got %h required %h", {bus.in_ready, bus.mem_we, bus.mem_addr, bus.mem_wdata, done, err, cpu_reset}, 29'h1);
        end
        vectors++;
        if ({mem[0], mem[1]} !== 32'h140A_0000) begin
            miscompares++;
            $display("FAIL midreset_mem: got %h required 140a0000", {mem[0], mem[1]});
        end
        @(negedge clk) reset = 1'b1;
        pulse_start();
        stream = '{8'h02, 8'h14, 8'h0A, 8'h15, 8'h0D, 8'h06};
        send_stream(1'b0);
        @(negedge clk);
        vectors++;
        if ({done, err, mem[0], mem[1]} !== {2'b10, 32'h140A_150D}) begin
            miscompares++;
            $display("FAIL midreset_reload: got %h required %h", {done, err, mem[0], mem[1]}, {2'b10, 32'h140A_150D});
        end
    endtask
    task automatic test_full_256();
        int w0, bad;
        logic [7:0] v;
        clear_mem();
        w0 = wr_cnt;
        pulse_start();
        stream = '{8'h00};
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            stream.push_back(v);
            stream.push_back(~v);
        end
        stream.push_back(8'h00);
        send_stream(1'b0);
        @(negedge clk);
        vectors++;
        if ({done, err, bus.mem_addr} !== {2'b10, 8'h00}) begin
            miscompares++;
            $display("FAIL full_flags_addr: done,err,mem_addr got %h required %h", {done, err, bus.mem_addr}, {2'b10, 8'h00});
        end
        vectors++;
        if (wr_cnt - w0 !== 256 || last_we_addr !== 8'hFF) begin
            miscompares++;
            $display("FAIL full_writes: writes %0d last_addr %h required 256 and ff", wr_cnt - w0, last_we_addr);
        end
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            v = 8'(i);
            if (mem[i] !== {v, ~v}) bad++;
        end
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL full_mem: %0d wrong words required 0", bad);
        end
    endtask
    task automatic test_start_mid_and_restart();
        int w0;
        clear_mem();
        w0 = wr_cnt;
        pulse_start();
        stream = '{8'h02, 8'h14};
        send_stream(1'b0);
        pulse_start();
        stream = '{8'h0A, 8'h15, 8'h0D, 8'h06};
        send_stream(1'b0);
        @(negedge clk);
        vectors++;
        if ({done, err, mem[0], mem[1]} !== {2'b10, 32'h140A_150D} || wr_cnt - w0 !== 2) begin
            miscompares++;
            $display("FAIL start_ignored: got %h writes %0d required %h writes 2", {done, err, mem[0], mem[1]}, wr_cnt - w0, {2'b10, 32'h140A_150D});
        end
        vectors++;
        if (cpu_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL start_before_restart: cpu_reset got %b required 0", cpu_reset);
        end
        pulse_start();
        vectors++;
        if ({cpu_reset, done, err, bus.in_ready} !== 4'b1001) begin
            miscompares++;
            $display("FAIL restart_after_done: cpu_reset,done,err,in_ready got %b required 1001", {cpu_reset, done, err, bus.in_ready});
        end
    endtask
    initial begin
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_random_valid();
        test_mid_reset();
        test_full_256();
        test_start_mid_and_restart();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mcpu_prog_loader.md
MCPU_PROG_LOADER -- requirements
Module: mcpu_prog_loader

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16, meaning the instruction word width written to RAM.
REQ-002 The block SHALL have parameter ADDR_SIZE, default 8, meaning the RAM address width (256 words).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port start  input  1  one-cycle request to begin a load.
REQ-006 The block SHALL have port in_valid  input  1  in_byte holds a valid stream byte.
REQ-007 The block SHALL have port in_byte  input  8  stream byte.
REQ-008 The block SHALL have port in_ready  output  1  loader accepts in_byte this cycle.
REQ-009 The block SHALL have port mem_we  output  1  one-cycle RAM write strobe.
REQ-010 The block SHALL have port mem_addr  output  ADDR_SIZE  RAM write address.
REQ-011 The block SHALL have port mem_wdata  output  WORD_SIZE  RAM write data, {high byte, low byte}.
REQ-012 The block SHALL have port cpu_reset  output  1  active-high reset driven to the MCPU; high while not loaded.
REQ-013 The block SHALL have port done  output  1  load completed with good checksum.
REQ-014 The block SHALL have port err  output  1  load completed with bad checksum.

Function
REQ-015 A byte SHALL transfer only in a cycle where in_valid and in_ready are both 1.
REQ-016 The stream format SHALL be: count byte N, then N words sent high byte first, then one checksum byte.
REQ-017 N=0 SHALL mean 256 words.
REQ-018 The checksum SHALL be the XOR of all 2N data bytes; the count byte is excluded.
REQ-019 The FSM states SHALL be IDLE, COUNT, HI, LO, WRITE, CHECK, DONE, ERROR.
REQ-020 The FSM SHALL move IDLE->COUNT on start; COUNT->HI on count byte; HI->LO on byte; LO->WRITE on byte.
REQ-021 The FSM SHALL move WRITE->HI if words remain, else WRITE->CHECK.
REQ-022 The FSM SHALL move CHECK->DONE on a checksum byte equal to the running XOR, else CHECK->ERROR.
REQ-023 in_ready SHALL be 1 in COUNT, HI, LO and CHECK, and 0 in all other states.
REQ-024 In WRITE, mem_we SHALL be 1 for exactly one cycle, in the cycle after the low byte is accepted; mem_wdata and mem_addr SHALL be stable in that cycle.
REQ-025 mem_addr SHALL be 0 for the first word and SHALL increment by 1 after each write.
REQ-026 For N=0 (256 words), mem_addr SHALL wrap from 255 to 0 after the last write, and that wrap SHALL end the data phase.
REQ-027 cpu_reset SHALL be 1 in every state except DONE.
REQ-028 done SHALL be 1 only in DONE; err SHALL be 1 only in ERROR; both SHALL hold until the next start or reset.
REQ-029 start SHALL be ignored in COUNT, HI, LO, WRITE and CHECK.
REQ-030 start in IDLE, DONE or ERROR SHALL clear the checksum, address and word counter, clear done and err, raise cpu_reset in the next cycle, and go to COUNT.
REQ-031 in_valid while in_ready=0 SHALL be ignored; the byte is not consumed.

Reset
REQ-032 reset=0 at a clock edge SHALL force IDLE and clear the address, word counter and checksum, in any state including mid-load.
REQ-033 During and after reset, outputs SHALL be in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, err=0, cpu_reset=1.
REQ-034 RAM words already written before a reset SHALL NOT be erased.

Verification
REQ-035 Bench SHALL cover: start; stream 02,14,0A,15,0D,checksum 06 -> mem[0]=140A and mem[1]=150D written one cycle after each low byte; done=1; cpu_reset falls.
REQ-036 Bench SHALL cover: same stream with checksum 07 -> two writes occur, err=1, done=0, cpu_reset stays 1.
REQ-037 Bench SHALL cover: in_valid toggled randomly during load -> identical RAM contents and done; no byte is lost or duplicated, and in_ready=0 in every WRITE cycle.
REQ-038 Bench SHALL cover: reset=0 after the 3rd data byte -> next cycle is IDLE with outputs at reset values; mem[0] is retained; a restarted full load completes with done=1.
REQ-039 Bench SHALL cover: count byte 00 with 512 data bytes -> 256 writes at addresses 0..255, mem_addr wraps to 0, done=1 on a correct checksum.
REQ-040 Bench SHALL cover: start pulsed mid-load -> ignored; start after done -> cpu_reset rises next cycle and done clears.
